// File: rtl/load_store_unit.sv
// load_store_unit: executes one byte/word load or store at a time against a
// single-port synchronous data RAM (4 KiB window, word indexed).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake; ready only while idle
//   opcode, addr, wdata   - access type, byte address, store data
//   done, misalign, rdata - completion pulse, lw/sw alignment fault, load result
//   mem_addr/mem_wren/mem_wdata/mem_rdata - data RAM port (1-cycle read latency)
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        misalign,
  output logic [31:0] rdata,
  output logic [9:0]  mem_addr,
  output logic        mem_wren,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MEM_AW = 10;
  localparam int unsigned ADDR_W = 12;

  localparam logic [5:0] OP_LB = 6'b000011;
  localparam logic [5:0] OP_SB = 6'b000111;
  localparam logic [5:0] OP_LW = 6'b001111;
  localparam logic [5:0] OP_SW = 6'b011111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                misalign_q, misalign_d;
  logic                req_ready_q, req_ready_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_wren_q, mem_wren_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [4:0]          lane_shift;
  logic [DATA_W-1:0]   byte_mask;
  logic [DATA_W-1:0]   merged_word;

  // Upper address bits fall outside the 4 KiB window and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W];

  // Byte-lane helpers for lb extraction and sb read-modify-write.
  always_comb begin
    lane_shift  = {addr_q[1:0], 3'b000};
    byte_mask   = 32'h0000_00FF << lane_shift;
    merged_word = (mem_rdata & ~byte_mask) | (DATA_W'(wdata_q[7:0]) << lane_shift);
  end

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = opcode;
          addr_d  = addr[ADDR_W-1:0];
          wdata_d = wdata;
          unique case (opcode)
            OP_LB, OP_SB: state_d = RD;
            OP_LW: begin
              if (addr[1:0] == 2'b00) begin
                state_d = RD;
              end else begin
                done_d     = 1'b1;
                misalign_d = 1'b1;
              end
            end
            OP_SW: begin
              if (addr[1:0] == 2'b00) begin
                state_d = WR;
              end else begin
                done_d     = 1'b1;
                misalign_d = 1'b1;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      RD: state_d = CAP;
      CAP: begin
        // RAM word is valid now: either finish the load or build the sb write word.
        if (op_q == OP_SB) begin
          wdata_d = merged_word;
          state_d = WR;
        end else begin
          if (op_q == OP_LB) begin
            rdata_d = DATA_W'(mem_rdata[lane_shift +: 8]);
          end else begin
            rdata_d = mem_rdata;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    mem_wren_d  = (state_d == WR);
    mem_addr_d  = ((state_d == RD) || (state_d == WR)) ? addr_d[ADDR_W-1:2] : '0;
    mem_wdata_d = (state_d == WR) ? wdata_d : '0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      req_ready_q <= 1'b1;
      mem_addr_q  <= '0;
      mem_wren_q  <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      req_ready_q <= req_ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wren_q  <= mem_wren_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign done      = done_q;
  assign misalign  = misalign_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wren  = mem_wren_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports, in order:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline access request.
- req_ready  out  1  unit idle and able to accept a request.
- opcode  in  6  access type: lb=000011, sb=000111, lw=001111, sw=011111.
- addr  in  32  byte address of the access.
- wdata  in  32  store data; sb uses wdata[7:0].
- done  out  1  one-cycle pulse when an access completes.
- misalign  out  1  valid with done; lw/sw had addr[1:0]!=0.
- rdata  out  32  load result; held until the next load completes.
- mem_addr  out  10  word index to the data RAM.
- mem_wren  out  1  RAM write enable.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data; valid the cycle after a read address is presented.
REQ-002 SHALL define acceptance as req_valid=1 and req_ready=1 at a rising edge; that is cycle 0, and all latencies below count from it.

Function
REQ-003 SHALL implement states IDLE, RD, CAP, WR; req_ready=1 only in IDLE.
REQ-004 SHALL latch opcode, addr and wdata at acceptance; later input changes SHALL NOT affect the in-flight access.
REQ-005 SHALL drive mem_addr=latched addr[11:2] in RD and WR, and 0 in IDLE.
REQ-006 SHALL drive mem_wren=1 only in WR.
REQ-007 lw (aligned) SHALL follow IDLE->RD(cycle 1)->CAP(cycle 2)->IDLE(cycle 3): capture mem_rdata at the end of CAP, set rdata=mem_rdata, and pulse done in cycle 3.
REQ-008 lb SHALL follow the lw sequence, except rdata={24'b0, byte lane addr[1:0]} of mem_rdata; lane 0=bits 7:0, lane 3=bits 31:24.
REQ-009 sw (aligned) SHALL follow IDLE->WR(cycle 1)->IDLE: mem_wdata=wdata in WR, done in cycle 2.
REQ-010 sb SHALL read-modify-write via IDLE->RD->CAP->WR(cycle 3)->IDLE, done in cycle 4.
- mem_wdata = the read word with lane addr[1:0] replaced by wdata[7:0].
- Other three bytes unchanged.
REQ-011 lw/sw with addr[1:0]!=0 SHALL perform no RAM access: done=1 and misalign=1 in cycle 1, state IDLE, rdata unchanged.
REQ-012 Any other opcode SHALL be accepted with no RAM access: done=1, misalign=0 in cycle 1.
REQ-013 lb/sb SHALL never flag misalign.
REQ-014 done SHALL be high for exactly one cycle per accepted request; req_ready SHALL be high in the done cycle, so back-to-back requests are allowed.
REQ-015 rdata SHALL change only on lb/lw completion; stores SHALL NOT alter it.
REQ-016 mem_wdata SHALL be 0 outside WR.
REQ-017 Address bits [31:12] SHALL be ignored (wrap modulo 4 KiB).

Reset
REQ-018 reset=1 at an edge SHALL force, from the next cycle:
- state=IDLE, req_ready=1;
- done=0, misalign=0, rdata=0;
- mem_wren=0, mem_addr=0, mem_wdata=0.
REQ-019 reset SHALL take priority over acceptance; a request presented with reset=1 SHALL be dropped.
REQ-020 Reset mid-access SHALL abort the access with no done pulse and no later RAM write.
- A WR cycle coinciding with the reset edge still writes at that edge.
- No further write SHALL follow.

Verification
REQ-021 Bench SHALL cover:
- sw addr=0x10, wdata=0xDEADBEEF -> mem_wren=1, mem_addr=4 in cycle 1; done cycle 2; then lw 0x10 -> rdata=0xDEADBEEF, done cycle 3.
- RAM[4]=0x11223344; lb addr=0x12 -> rdata=0x00000022; lb addr=0x13 -> 0x00000011.
- RAM[4]=0x11223344; sb addr=0x11, wdata=0xAB -> write of 0x1122AB44 in cycle 3, done cycle 4.
- lw addr=0x06 -> done=1, misalign=1 in cycle 1, mem_wren never 1, rdata unchanged.
- sb accepted, reset=1 during CAP -> no write, no done, req_ready=1 next cycle, outputs at reset values.
- Back-to-back sw then lw, each accepted in its predecessor's done cycle -> no idle gap, correct data.
